// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline-stage hazard info in, stage control and forwarding selects out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    // debug
    logic              debug_en;
    logic              debug_step;
    // ID stage
    logic [REG_AW-1:0] id_rs_addr;
    logic [REG_AW-1:0] id_rt_addr;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_is_store;
    logic              id_is_mdu;
    logic              id_branch_taken;
    logic [REG_AW-1:0] id_mdu_waddr;
    // EXE / MEM / WB writeback info
    logic              exe_wen;
    logic              exe_is_load;
    logic [REG_AW-1:0] exe_waddr;
    logic              mem_wen;
    logic              mem_is_load;
    logic [REG_AW-1:0] mem_waddr;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_waddr;
    // stage control
    logic              if_en, id_en, exe_en, mem_en, wb_en;
    logic              if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    // forwarding and status
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_fwd_store;
    logic              mdu_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output debug_en, debug_step,
        output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_store, id_is_mdu,
        output id_branch_taken, id_mdu_waddr,
        output exe_wen, exe_is_load, exe_waddr, mem_wen, mem_is_load, mem_waddr,
        output wb_wen, wb_waddr,
        input  if_en, id_en, exe_en, mem_en, wb_en,
        input  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        input  fwd_a, fwd_b, mem_fwd_store, mdu_busy, stall_cnt
    );

    modport slave (
        input  debug_en, debug_step,
        input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_is_store, id_is_mdu,
        input  id_branch_taken, id_mdu_waddr,
        input  exe_wen, exe_is_load, exe_waddr, mem_wen, mem_is_load, mem_waddr,
        input  wb_wen, wb_waddr,
        output if_en, id_en, exe_en, mem_en, wb_en,
        output if_rst, id_rst, exe_rst, mem_rst, wb_rst,
        output fwd_a, fwd_b, mem_fwd_store, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use and MDU interlocks, operand forwarding,
// branch flush, debug freeze/single-step and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned    MCW     = $clog2(MDU_LAT);
    localparam logic [MCW-1:0] MduLoad = MCW'(MDU_LAT - 1);

    typedef enum logic {StIdle, StBusy} mdu_state_e;

    mdu_state_e        state_q, state_d;
    logic [MCW-1:0]    cnt_q, cnt_d;
    logic [REG_AW-1:0] mdu_waddr_q, mdu_waddr_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              step_q;

    logic freeze, load_stall, mdu_stall, stall;

    // Register $0 is hard-wired zero, so it never creates a dependency.
    function automatic logic addr_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // A debug step is the rising edge of debug_step; anything else freezes while debug_en.
    assign freeze = bus.debug_en && !(bus.debug_step && !step_q);

    assign load_stall = bus.exe_wen && bus.exe_is_load &&
                        ((bus.id_rs_used && addr_hit(bus.id_rs_addr, bus.exe_waddr)) ||
                         (bus.id_rt_used && addr_hit(bus.id_rt_addr, bus.exe_waddr) &&
                          !bus.id_is_store));

    assign mdu_stall = (state_q == StBusy) &&
                       (bus.id_is_mdu ||
                        (bus.id_rs_used && addr_hit(bus.id_rs_addr, mdu_waddr_q)) ||
                        (bus.id_rt_used && addr_hit(bus.id_rt_addr, mdu_waddr_q)));

    assign stall = load_stall || mdu_stall;

    // State registers: MDU FSM, latency counter, latched MDU destination, stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mdu_waddr_q <= '0;
            stall_cnt_q <= '0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mdu_waddr_q <= mdu_waddr_d;
            stall_cnt_q <= stall_cnt_d;
            step_q      <= bus.debug_step;
        end
    end

    // Next state: nothing advances while frozen; an MDU op issues only if ID is not stalled.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mdu_waddr_d = mdu_waddr_q;
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.id_is_mdu && !stall) begin
                        state_d     = StBusy;
                        cnt_d       = MduLoad;
                        mdu_waddr_d = bus.id_mdu_waddr;
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - MCW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage control, priority: reset > freeze > stall > branch flush > normal.
    always_comb begin
        bus.if_en   = 1'b1;
        bus.id_en   = 1'b1;
        bus.exe_en  = 1'b1;
        bus.mem_en  = 1'b1;
        bus.wb_en   = 1'b1;
        bus.if_rst  = 1'b0;
        bus.id_rst  = 1'b0;
        bus.exe_rst = 1'b0;
        bus.mem_rst = 1'b0;
        bus.wb_rst  = 1'b0;
        if (rst) begin
            bus.if_rst  = 1'b1;
            bus.id_rst  = 1'b1;
            bus.exe_rst = 1'b1;
            bus.mem_rst = 1'b1;
            bus.wb_rst  = 1'b1;
        end else if (freeze) begin
            bus.if_en  = 1'b0;
            bus.id_en  = 1'b0;
            bus.exe_en = 1'b0;
            bus.mem_en = 1'b0;
            bus.wb_en  = 1'b0;
        end else if (stall) begin
            // Hold IF/ID and push a bubble into EXE.
            bus.if_en   = 1'b0;
            bus.id_en   = 1'b0;
            bus.exe_rst = 1'b1;
        end else if (bus.id_branch_taken) begin
            bus.id_rst = 1'b1;
        end
    end

    // Forwarding selects: MEM stage wins over WB; load data in MEM uses the load path.
    always_comb begin
        bus.fwd_a         = 2'b00;
        bus.fwd_b         = 2'b00;
        bus.mem_fwd_store = 1'b0;
        if (!rst) begin
            if (bus.mem_wen && addr_hit(bus.id_rs_addr, bus.mem_waddr)) begin
                bus.fwd_a = bus.mem_is_load ? 2'b10 : 2'b01;
            end else if (bus.wb_wen && addr_hit(bus.id_rs_addr, bus.wb_waddr)) begin
                bus.fwd_a = 2'b11;
            end
            if (bus.mem_wen && addr_hit(bus.id_rt_addr, bus.mem_waddr)) begin
                bus.fwd_b = bus.mem_is_load ? 2'b10 : 2'b01;
            end else if (bus.wb_wen && addr_hit(bus.id_rt_addr, bus.wb_waddr)) begin
                bus.fwd_b = 2'b11;
            end
            // Store data only needed in MEM, so the load result is forwarded there instead.
            bus.mem_fwd_store = bus.exe_wen && bus.exe_is_load && bus.id_is_store &&
                                bus.id_rt_used && addr_hit(bus.id_rt_addr, bus.exe_waddr);
        end
    end

    assign bus.mdu_busy  = (state_q == StBusy) && !rst;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-scenario tasks, expectations via a scoreboard.
module tb_pipe_hazard_ctrl;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MDU_LAT = 4;
    localparam int unsigned CNT_W   = 4;

    // {if,id,exe,mem,wb}_en, {..}_rst, fwd_a, fwd_b, mem_fwd_store, mdu_busy, stall_cnt
    typedef logic [5+5+2+2+1+1+CNT_W-1:0] vec_t;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_STL  = 5'b00111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] RS_NONE = 5'b00000;
    localparam logic [4:0] RS_STL  = 5'b00100;
    localparam logic [4:0] RS_BR   = 5'b01000;
    localparam logic [4:0] RS_ALL  = 5'b11111;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    vec_t sb[$];

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW (REG_AW),
        .MDU_LAT(MDU_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t ev(input logic [4:0] en, input logic [4:0] rs, input logic [1:0] fa,
                                input logic [1:0] fb, input logic mfs, input logic busy,
                                input logic [CNT_W-1:0] cnt);
        return {en, rs, fa, fb, mfs, busy, cnt};
    endfunction

    function automatic vec_t sample();
        return {bus.if_en, bus.id_en, bus.exe_en, bus.mem_en, bus.wb_en,
                bus.if_rst, bus.id_rst, bus.exe_rst, bus.mem_rst, bus.wb_rst,
                bus.fwd_a, bus.fwd_b, bus.mem_fwd_store, bus.mdu_busy, bus.stall_cnt};
    endfunction

    task automatic clear_in();
        bus.debug_en = 0; bus.debug_step = 0;
        bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rs_used = 0; bus.id_rt_used = 0;
        bus.id_is_store = 0; bus.id_is_mdu = 0; bus.id_branch_taken = 0; bus.id_mdu_waddr = 0;
        bus.exe_wen = 0; bus.exe_is_load = 0; bus.exe_waddr = 0;
        bus.mem_wen = 0; bus.mem_is_load = 0; bus.mem_waddr = 0;
        bus.wb_wen = 0; bus.wb_waddr = 0;
    endtask

    task automatic exe_load(input logic [REG_AW-1:0] a);
        bus.exe_wen = 1; bus.exe_is_load = 1; bus.exe_waddr = a;
    endtask

    task automatic rs_use(input logic [REG_AW-1:0] a);
        bus.id_rs_addr = a; bus.id_rs_used = 1;
    endtask

    task automatic rt_use(input logic [REG_AW-1:0] a);
        bus.id_rt_addr = a; bus.id_rt_used = 1;
    endtask

    task automatic mdu_issue(input logic [REG_AW-1:0] a);
        bus.id_is_mdu = 1; bus.id_mdu_waddr = a;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_reset();
        vec_t got, want;
        for (int i = 0; i < 2; i++) begin
            clear_in();
            case (i)
                0: begin
                    rst = 1;
                    exe_load(5); rs_use(5); rt_use(5); bus.id_is_store = 1;
                    bus.mem_wen = 1; bus.mem_waddr = 5; bus.wb_wen = 1; bus.wb_waddr = 5;
                    sb.push_back(ev(EN_ALL, RS_ALL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                default: begin
                    rst = 0;
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL reset[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_in();
            case (i)
                0: begin
                    exe_load(5); rs_use(5);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                1: begin
                    bus.mem_wen = 1; bus.mem_is_load = 1; bus.mem_waddr = 5; rs_use(5);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b10, 2'b00, 1'b0, 1'b0, 4'd1));
                end
                2: begin
                    exe_load(6); rt_use(6);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1));
                end
                3: begin
                    exe_load(6); bus.id_rt_addr = 6;
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd2));
                end
                4: begin
                    // MDU issue blocked by a load-use stall
                    exe_load(6); rs_use(6); mdu_issue(11);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd2));
                end
                default: begin
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL load_use[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            clear_in();
            case (i)
                0: begin
                    bus.mem_wen = 1; bus.mem_waddr = 3; bus.wb_wen = 1; bus.wb_waddr = 3;
                    rs_use(3); rt_use(3);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b01, 2'b01, 1'b0, 1'b0, 4'd0));
                end
                1: begin
                    bus.mem_wen = 1; bus.mem_waddr = 0; bus.wb_wen = 1; bus.wb_waddr = 3;
                    rs_use(3); rt_use(4);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b11, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                2: begin
                    // $0 never matches anything
                    bus.mem_wen = 1; bus.wb_wen = 1; exe_load(0); rs_use(0); rt_use(0);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                3: begin
                    bus.mem_wen = 1; bus.mem_is_load = 1; bus.mem_waddr = 4;
                    bus.wb_wen = 1; bus.wb_waddr = 3; rs_use(3); rt_use(4);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b11, 2'b10, 1'b0, 1'b0, 4'd0));
                end
                default: begin
                    bus.mem_waddr = 3; bus.wb_waddr = 3; rs_use(3); rt_use(3);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL forward[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_fwd();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_in();
            exe_load(7); rs_use(2);
            case (i)
                0: begin
                    rt_use(7); bus.id_is_store = 1;
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b1, 1'b0, 4'd0));
                end
                1: begin
                    rt_use(7);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                2: begin
                    bus.id_rt_addr = 7; bus.id_is_store = 1;
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1));
                end
                default: begin
                    bus.exe_wen = 0; rt_use(7); bus.id_is_store = 1;
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL store_fwd[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mdu();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            clear_in();
            case (i)
                0: begin
                    mdu_issue(9);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                1: begin
                    rs_use(2); bus.id_rt_addr = 9;
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0));
                end
                2: begin
                    rs_use(9);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0));
                end
                3: begin
                    rs_use(9);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1));
                end
                4: begin
                    rt_use(9);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'd2));
                end
                5: begin
                    rs_use(9);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3));
                end
                default: begin
                    rt_use(9);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd3));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL mdu[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_in();
            case (i)
                0: begin
                    bus.id_branch_taken = 1;
                    sb.push_back(ev(EN_ALL, RS_BR, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                1: begin
                    bus.id_branch_taken = 1; exe_load(5); rs_use(5);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                2: begin
                    bus.id_branch_taken = 1; mdu_issue(12);
                    sb.push_back(ev(EN_ALL, RS_BR, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1));
                end
                default: begin
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL branch[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_debug();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            clear_in();
            bus.debug_en = (i < 7);
            case (i)
                0: begin
                    mdu_issue(9);
                    sb.push_back(ev(EN_NONE, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                1: begin
                    bus.debug_step = 1; mdu_issue(9);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                2, 3: begin
                    bus.debug_step = 1;
                    sb.push_back(ev(EN_NONE, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0));
                end
                4: begin
                    sb.push_back(ev(EN_NONE, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0));
                end
                5: begin
                    bus.debug_step = 1; bus.id_is_mdu = 1;
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0));
                end
                6: begin
                    bus.debug_step = 1; bus.id_is_mdu = 1;
                    sb.push_back(ev(EN_NONE, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1));
                end
                7, 8, 9: begin
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1));
                end
                default: begin
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL debug[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rst_busy();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            clear_in();
            case (i)
                0: begin
                    mdu_issue(9);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                1: begin
                    rs_use(9);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'd0));
                end
                2: begin
                    rst = 1; rs_use(9);
                    sb.push_back(ev(EN_ALL, RS_ALL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1));
                end
                default: begin
                    rst = 0; rs_use(9);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL rst_busy[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
        rst = 0;
    endtask

    task automatic test_back_to_back();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            clear_in();
            case (i)
                0: begin
                    mdu_issue(10);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0));
                end
                1, 2, 3, 4: begin
                    mdu_issue(10);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'(i - 1)));
                end
                5: begin
                    mdu_issue(10);
                    sb.push_back(ev(EN_ALL, RS_NONE, 2'b00, 2'b00, 1'b0, 1'b0, 4'd4));
                end
                default: begin
                    exe_load(5); rs_use(5);
                    sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b1, 4'd4));
                end
            endcase
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        vec_t got, want;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            clear_in();
            exe_load(5); rs_use(5);
            sb.push_back(ev(EN_STL, RS_STL, 2'b00, 2'b00, 1'b0, 1'b0,
                            (i < 15) ? 4'(i) : 4'd15));
            @(negedge clk);
            got = sample(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL saturation[%0d]: got %h required %h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1;
        clear_in();
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_forward();
        test_store_fwd();
        test_mdu();
        test_branch();
        test_debug();
        test_rst_busy();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REG_AW  default 5  register address width.
MDU_LAT  default 4  multi-cycle (mul/div) unit latency in cycles, >=2.
CNT_W  default 16  stall performance counter width.
REQ-001 clk  in  1  main clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 debug_en, debug_step  in  1 each  debug freeze and single-step request.
REQ-004 id_rs_addr, id_rt_addr  in  REG_AW each  source registers of the ID-stage instruction.
REQ-005 id_rs_used, id_rt_used, id_is_store, id_is_mdu, id_branch_taken  in  1 each  ID-stage decode flags.
REQ-006 id_mdu_waddr  in  REG_AW  destination register of an MDU op in ID.
REQ-007 exe_wen, exe_is_load  in  1 each; exe_waddr  in  REG_AW  EXE-stage writeback info.
REQ-008 mem_wen, mem_is_load  in  1 each; mem_waddr  in  REG_AW  MEM-stage writeback info.
REQ-009 wb_wen  in  1; wb_waddr  in  REG_AW  WB-stage writeback info.
REQ-010 if_en, id_en, exe_en, mem_en, wb_en  out  1 each  stage enables.
REQ-011 if_rst, id_rst, exe_rst, mem_rst, wb_rst  out  1 each  stage resets (bubble insert).
REQ-012 fwd_a, fwd_b  out  2 each  operand source: 00 REG, 01 MEM-stage ALU, 10 MEM-stage load data, 11 WB data.
REQ-013 mem_fwd_store  out  1  store data taken from load result in MEM.
REQ-014 mdu_busy  out  1; stall_cnt  out  CNT_W  MDU active flag; total stall cycles.

Function
REQ-015 Address 0 SHALL never match any hazard or forwarding comparison.
REQ-016 fwd_a/fwd_b SHALL select MEM-stage source (01, or 10 if mem_is_load) when mem_wen and mem_waddr equals the operand address; else 11 when wb_wen and wb_waddr matches; else 00. MEM priority over WB.
REQ-017 load_stall SHALL assert combinationally when exe_wen & exe_is_load & exe_waddr!=0 and (id_rs_used & rs match, or id_rt_used & rt match & ~id_is_store).
REQ-018 mem_fwd_store SHALL assert when exe load matches id_rt_addr with id_is_store & id_rt_used; no stall in that case.
REQ-019 MDU FSM states IDLE, BUSY; IDLE->BUSY when id_is_mdu and ID not stalled/frozen, loading counter with MDU_LAT-1 and latching id_mdu_waddr.
REQ-020 In BUSY counter SHALL decrement each unfrozen cycle; BUSY->IDLE on the cycle counter reaches 0; mdu_busy=1 exactly while BUSY.
REQ-021 mdu_stall SHALL assert while BUSY if the ID instruction is id_is_mdu, or uses a source matching the latched MDU destination (nonzero).
REQ-022 Stall (load_stall | mdu_stall) SHALL give if_en=0, id_en=0, exe_rst=1; later stages enabled.
REQ-023 id_branch_taken with no stall SHALL give id_rst=1 (one bubble replacing the wrong-path fetch); ignored while stalled.
REQ-024 Control priority: rst > debug freeze > stall > branch flush > normal (all en=1, all rst=0).
REQ-025 Debug: register debug_step each cycle; when debug_en and no rising edge of debug_step, all en=0 and FSM/counter/stall_cnt hold; a rising edge advances exactly one cycle.
REQ-026 stall_cnt SHALL increment once per cycle in which a stall is applied, saturating at all-ones.
REQ-027 An MDU issue and branch in the same cycle SHALL both take effect (FSM enters BUSY, id_rst=1).

Reset
REQ-028 rst SHALL force all *_rst=1, all *_en=1, FSM IDLE, counter 0, latched address 0, stall_cnt 0, debug_step history 0, fwd_a=fwd_b=00, mem_fwd_store=0, mdu_busy=0; rst mid-BUSY aborts to IDLE.

Verification
REQ-029 EXE lw $5, ID add uses rs=$5 -> if_en=0,id_en=0,exe_rst=1 one cycle; next cycle fwd_a=10; stall_cnt=1.
REQ-030 MEM add $3 and WB add $3, ID rs=$3 -> fwd_a=01; MEM waddr=0 case -> fwd_a=11 from WB only if wb_waddr=3.
REQ-031 EXE lw $7, ID sw rt=$7 -> no stall, mem_fwd_store=1.
REQ-032 MDU issue dest $9 (MDU_LAT=4), then ID uses $9 -> mdu_busy 4 cycles, stall until IDLE, stall_cnt=3.
REQ-033 debug_en=1, debug_step held high -> no advance; one 0->1 edge -> exactly one cycle of progress.
REQ-034 rst asserted in BUSY cycle 2 -> next cycle mdu_busy=0, stall_cnt=0, all stage resets observed.
